// File: rtl/irq_controller_if.sv
// irq_controller_if
// Groups the CPU-facing signals of the interrupt controller: the 4-word
// config window on the data bus and the IRQ/IRQn/IRQAck handshake.
//   cfgWrEn    - config write strobe, one cycle per write
//   cfgAddr    - config word select (0 ENABLE, 1 PENDING, 2 EDGE, 3 STATUS/EOI)
//   cfgDataIn  - config write data
//   cfgDataOut - config read data, combinational from cfgAddr
//   IRQ        - interrupt request to the core
//   IRQn       - 12-bit handler vector, valid while IRQ is high
//   IRQAck     - acknowledge from the core
// The master modport is the CPU side; the slave modport is the controller.
interface irq_controller_if;
  logic        cfgWrEn;
  logic [1:0]  cfgAddr;
  logic [31:0] cfgDataIn;
  logic [31:0] cfgDataOut;
  logic        IRQ;
  logic [11:0] IRQn;
  logic        IRQAck;

  modport master (
    output cfgWrEn, cfgAddr, cfgDataIn, IRQAck,
    input  cfgDataOut, IRQ, IRQn
  );

  modport slave (
    input  cfgWrEn, cfgAddr, cfgDataIn, IRQAck,
    output cfgDataOut, IRQ, IRQn
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
// Priority interrupt controller for up to 16 peripheral lines. Each line is
// synchronized, latched into PENDING (edge or level mode), masked by ENABLE,
// and the lowest-numbered candidate is presented to the core as IRQ plus a
// 12-bit vector. No new request is issued until software writes STATUS (EOI).
// Ports:
//   clk    - system clock (shared with the core)
//   nRst   - asynchronous active-low reset
//   irqSrc - raw interrupt lines, asynchronous to clk
//   bus    - config window and IRQ handshake (slave side)
module irq_controller #(
  parameter int unsigned NSRC       = 8,
  parameter logic [11:0] VEC_BASE   = 12'h010,
  parameter logic [11:0] VEC_STRIDE = 12'h004
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [NSRC-1:0] irqSrc,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] edge_mode_q, edge_mode_d;
  logic [3:0]      idx_q, idx_d;
  logic            eoi_seen_q, eoi_seen_d;
  logic            irq_q, irq_d;
  logic [11:0]     irqn_q, irqn_d;

  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c_mask;
  logic [NSRC-1:0] ack_clr;
  logic [3:0]      win_idx;
  logic [11:0]     win_vec;
  logic            wr_enable, wr_pending, wr_edge, wr_eoi;
  logic [31:0]     rd_data;
  logic            unused_cfg_bits;

  assign wr_enable  = bus.cfgWrEn && (bus.cfgAddr == 2'd0);
  assign wr_pending = bus.cfgWrEn && (bus.cfgAddr == 2'd1);
  assign wr_edge    = bus.cfgWrEn && (bus.cfgAddr == 2'd2);
  assign wr_eoi     = bus.cfgWrEn && (bus.cfgAddr == 2'd3);

  // Data bits above the implemented sources are ignored on write.
  assign unused_cfg_bits = ^bus.cfgDataIn;

  assign rise     = s2_q & ~s3_q;
  assign cand     = pending_q & enable_q;
  assign w1c_mask = wr_pending ? bus.cfgDataIn[NSRC-1:0] : '0;

  // The acknowledged source is the latched idx, not the current winner.
  always_comb begin
    ack_clr = '0;
    if (state_q == ST_REQ && bus.IRQAck) begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (idx_q == 4'(i)) ack_clr[i] = 1'b1;
      end
    end
  end

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_idx = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = 4'(i);
    end
    win_vec = VEC_BASE + 12'(win_idx) * VEC_STRIDE;
  end

  // Edge bits: a new edge beats both W1C and the ack clear.
  // Level bits simply follow the synchronized line.
  always_comb begin
    pending_d   = (edge_mode_q & ((pending_q & ~(w1c_mask | ack_clr)) | rise))
                | (~edge_mode_q & s2_q);
    enable_d    = wr_enable ? bus.cfgDataIn[NSRC-1:0] : enable_q;
    edge_mode_d = wr_edge   ? bus.cfgDataIn[NSRC-1:0] : edge_mode_q;
  end

  // Request state machine: IRQ and IRQn are registered so they stay stable
  // for the whole REQ state regardless of ENABLE or PENDING changes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    irq_d      = irq_q;
    irqn_d     = irqn_q;
    eoi_seen_d = eoi_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          idx_d   = win_idx;
          irq_d   = 1'b1;
          irqn_d  = win_vec;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.IRQAck) begin
          irq_d   = 1'b0;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        // An EOI that lands while the core still holds IRQAck is remembered
        // so the controller leaves SERVICE once the ack drops.
        if (wr_eoi || eoi_seen_q) begin
          if (bus.IRQAck) begin
            eoi_seen_d = 1'b1;
          end else begin
            eoi_seen_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      enable_q    <= '0;
      pending_q   <= '0;
      edge_mode_q <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      eoi_seen_q  <= 1'b0;
      irq_q       <= 1'b0;
      irqn_q      <= '0;
    end else begin
      s1_q        <= irqSrc;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      edge_mode_q <= edge_mode_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      eoi_seen_q  <= eoi_seen_d;
      irq_q       <= irq_d;
      irqn_q      <= irqn_d;
    end
  end

  // Zero-latency read mux; unimplemented bits read as 0.
  always_comb begin
    rd_data = '0;
    case (bus.cfgAddr)
      2'd0: rd_data[NSRC-1:0] = enable_q;
      2'd1: rd_data[NSRC-1:0] = pending_q;
      2'd2: rd_data[NSRC-1:0] = edge_mode_q;
      default: rd_data = {(state_q != ST_IDLE), 27'b0, idx_q};
    endcase
  end

  assign bus.cfgDataOut = rd_data;
  assign bus.IRQ        = irq_q;
  assign bus.IRQn       = irqn_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Self-checking bench for irq_controller: a register-map vector table, a set
// of hand-written multi-cycle sequences, and a randomized run compared
// against a behavioural model of the controller kept in this file.
module tb_irq_controller;

  localparam int          NSRC       = 8;
  localparam logic [11:0] VEC_BASE   = 12'h010;
  localparam logic [11:0] VEC_STRIDE = 12'h004;

  logic            clk;
  logic            nRst;
  logic [NSRC-1:0] irqSrc;

  irq_controller_if bus();

  irq_controller #(
    .NSRC      (NSRC),
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE)
  ) dut (
    .clk   (clk),
    .nRst  (nRst),
    .irqSrc(irqSrc),
    .bus   (bus)
  );

  int vectors;
  int miscompares;

  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t reg_tbl[11];

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounded run time so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfgWrEn   = 1'b1;
    bus.cfgAddr   = a;
    bus.cfgDataIn = d;
    tick();
    bus.cfgWrEn   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    bus.cfgAddr = a;
    #1;
    v = bus.cfgDataOut;
  endtask

  task automatic ack_cycle();
    bus.IRQAck = 1'b1;
    tick();
    bus.IRQAck = 1'b0;
  endtask

  task automatic do_reset();
    irqSrc        = '0;
    bus.cfgWrEn   = 1'b0;
    bus.cfgAddr   = 2'd0;
    bus.cfgDataIn = '0;
    bus.IRQAck    = 1'b0;
    @(negedge clk);
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic applyStimulus(input reg_vec_t v, input int n);
    logic [31:0] act;
    if (v.wr) cfg_write(v.waddr, v.wdata);
    else tick();
    read_reg(v.raddr, act);
    checkOutput($sformatf("regmap[%0d]", n), act, v.exp);
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_s1[NSRC], m_s2[NSRC], m_s3[NSRC];
  bit m_en[NSRC], m_pend[NSRC], m_edge[NSRC];
  int m_phase;          // 0 waiting, 1 requesting, 2 in handler
  int m_idx;
  bit m_irq;
  int m_vec;
  bit m_eoi_pending;

  function automatic void model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_s3[i] = 0;
      m_en[i] = 0; m_pend[i] = 0; m_edge[i] = 0;
    end
    m_phase = 0; m_idx = 0; m_irq = 0; m_vec = 0; m_eoi_pending = 0;
  endfunction

  function automatic void model_edge(input logic [NSRC-1:0] src, input bit wr, input int addr,
                                     input logic [31:0] data, input bit ack);
    bit n_pend[NSRC];
    int winner;
    bit eoi;
    winner = -1;
    eoi = wr && (addr == 3);
    for (int i = 0; i < NSRC; i++)
      if (winner < 0 && m_pend[i] && m_en[i]) winner = i;
    for (int i = 0; i < NSRC; i++) begin
      if (m_edge[i]) begin
        if (m_s2[i] && !m_s3[i]) n_pend[i] = 1;
        else if ((wr && addr == 1 && data[i]) || (m_phase == 1 && ack && m_idx == i)) n_pend[i] = 0;
        else n_pend[i] = m_pend[i];
      end else begin
        n_pend[i] = m_s2[i];
      end
    end
    case (m_phase)
      0: if (winner >= 0) begin
           m_phase = 1; m_idx = winner; m_irq = 1;
           m_vec = (int'(VEC_BASE) + winner * int'(VEC_STRIDE)) % 4096;
         end
      1: if (ack) begin m_phase = 2; m_irq = 0; end
      default: if (eoi || m_eoi_pending) begin
           if (ack) m_eoi_pending = 1;
           else begin m_eoi_pending = 0; m_phase = 0; end
         end
    endcase
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = n_pend[i];
      if (wr && addr == 0) m_en[i] = data[i];
      if (wr && addr == 2) m_edge[i] = data[i];
      m_s3[i] = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = src[i];
    end
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (addr == 0) r[i] = m_en[i];
      if (addr == 1) r[i] = m_pend[i];
      if (addr == 2) r[i] = m_edge[i];
    end
    if (addr == 3) r = {(m_phase != 0), 27'b0, 4'(m_idx)};
    return r;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0]     rd;
    logic [NSRC-1:0] p_src;
    bit              p_wr, p_ack;
    int              p_addr;
    logic [31:0]     p_data;

    vectors = 0;
    miscompares = 0;
    nRst = 1'b0;

    reg_tbl[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
    reg_tbl[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
    reg_tbl[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    reg_tbl[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
    reg_tbl[4]  = '{1'b1, 2'd0, 32'hFFFFFFFF, 2'd0, 32'h000000FF};
    reg_tbl[5]  = '{1'b1, 2'd2, 32'h5A5A5AA5, 2'd2, 32'h000000A5};
    reg_tbl[6]  = '{1'b1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'h0};
    reg_tbl[7]  = '{1'b1, 2'd3, 32'h0,        2'd3, 32'h0};
    reg_tbl[8]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h000000FF};
    reg_tbl[9]  = '{1'b1, 2'd0, 32'h00000100, 2'd0, 32'h0};
    reg_tbl[10] = '{1'b1, 2'd2, 32'hFFFFFF00, 2'd2, 32'h0};

    do_reset();
    // Outputs while reset is still asserted
    nRst = 1'b0;
    #1;
    checkOutput("reset IRQ", 32'(bus.IRQ), 32'h0);
    checkOutput("reset IRQn", 32'(bus.IRQn), 32'h0);
    @(negedge clk);
    nRst = 1'b1;

    $display("[TB] register map table");
    for (int n = 0; n < 11; n++) applyStimulus(reg_tbl[n], n);

    $display("[TB] single edge source");
    cfg_write(2'd2, 32'h3);
    cfg_write(2'd0, 32'h3);
    irqSrc = 8'h02;
    tick();
    irqSrc = 8'h00;
    tick(2);
    checkOutput("t1 IRQ before k+3", 32'(bus.IRQ), 32'h0);
    read_reg(2'd1, rd);
    checkOutput("t1 PENDING at k+2", rd, 32'h2);
    tick();
    checkOutput("t1 IRQ at k+3", 32'(bus.IRQ), 32'h1);
    checkOutput("t1 IRQn", 32'(bus.IRQn), 32'h014);
    ack_cycle();
    checkOutput("t1 IRQ after ack", 32'(bus.IRQ), 32'h0);
    read_reg(2'd1, rd);
    checkOutput("t1 PENDING after ack", rd, 32'h0);
    read_reg(2'd3, rd);
    checkOutput("t1 STATUS in service", rd, 32'h80000001);
    cfg_write(2'd3, 32'h0);
    read_reg(2'd3, rd);
    checkOutput("t1 STATUS after EOI", rd, 32'h00000001);

    $display("[TB] two simultaneous edges");
    cfg_write(2'd2, 32'hFF);
    cfg_write(2'd0, 32'hFF);
    irqSrc = 8'h24;
    tick(4);
    checkOutput("t2 IRQ first", 32'(bus.IRQ), 32'h1);
    checkOutput("t2 IRQn first", 32'(bus.IRQn), 32'h018);
    ack_cycle();
    read_reg(2'd1, rd);
    checkOutput("t2 PENDING after ack", rd, 32'h20);
    cfg_write(2'd3, 32'h0);
    checkOutput("t2 IRQ right after EOI", 32'(bus.IRQ), 32'h0);
    tick();
    checkOutput("t2 IRQ second", 32'(bus.IRQ), 32'h1);
    checkOutput("t2 IRQn second", 32'(bus.IRQn), 32'h024);
    ack_cycle();
    cfg_write(2'd3, 32'h0);
    irqSrc = 8'h00;
    tick(3);
    checkOutput("t2 IRQ quiet", 32'(bus.IRQ), 32'h0);

    $display("[TB] level mode retrigger");
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd2, 32'h00);
    irqSrc = 8'h01;
    tick(4);
    checkOutput("t3 IRQ level", 32'(bus.IRQ), 32'h1);
    checkOutput("t3 IRQn level", 32'(bus.IRQn), 32'h010);
    ack_cycle();
    cfg_write(2'd3, 32'h0);
    checkOutput("t3 IRQ at IDLE", 32'(bus.IRQ), 32'h0);
    tick();
    checkOutput("t3 IRQ retrigger", 32'(bus.IRQ), 32'h1);
    checkOutput("t3 IRQn retrigger", 32'(bus.IRQn), 32'h010);
    ack_cycle();
    irqSrc = 8'h00;
    tick(2);
    read_reg(2'd1, rd);
    checkOutput("t3 PENDING still set", rd, 32'h1);
    tick();
    read_reg(2'd1, rd);
    checkOutput("t3 PENDING cleared", rd, 32'h0);
    cfg_write(2'd3, 32'h0);
    tick(2);
    checkOutput("t3 no retrigger", 32'(bus.IRQ), 32'h0);

    $display("[TB] EOI during ack");
    cfg_write(2'd2, 32'hFF);
    cfg_write(2'd0, 32'hFF);
    irqSrc = 8'h0C;
    tick(4);
    checkOutput("t4 IRQn first", 32'(bus.IRQn), 32'h018);
    bus.IRQAck = 1'b1;
    tick();
    cfg_write(2'd3, 32'h0);
    tick();
    checkOutput("t4 IRQ ack held", 32'(bus.IRQ), 32'h0);
    read_reg(2'd3, rd);
    checkOutput("t4 STATUS ack held", rd, 32'h80000002);
    bus.IRQAck = 1'b0;
    tick();
    checkOutput("t4 IRQ ack dropped", 32'(bus.IRQ), 32'h0);
    read_reg(2'd3, rd);
    checkOutput("t4 STATUS idle", rd, 32'h00000002);
    tick();
    checkOutput("t4 IRQ next", 32'(bus.IRQ), 32'h1);
    checkOutput("t4 IRQn next", 32'(bus.IRQn), 32'h01C);
    ack_cycle();
    cfg_write(2'd3, 32'h0);
    irqSrc = 8'h00;
    tick(3);

    $display("[TB] W1C against new edge, ENABLE cleared in REQ");
    cfg_write(2'd0, 32'h00);
    irqSrc = 8'h10;
    tick(3);
    irqSrc = 8'h00;
    tick(3);
    read_reg(2'd1, rd);
    checkOutput("t5 PENDING latched", rd, 32'h10);
    irqSrc = 8'h10;
    tick(2);
    cfg_write(2'd1, 32'h10);
    read_reg(2'd1, rd);
    checkOutput("t5 W1C vs edge", rd, 32'h10);
    cfg_write(2'd1, 32'h10);
    read_reg(2'd1, rd);
    checkOutput("t5 W1C alone", rd, 32'h00);
    irqSrc = 8'h00;
    cfg_write(2'd0, 32'h01);
    irqSrc = 8'h01;
    tick(4);
    checkOutput("t5 IRQ raised", 32'(bus.IRQ), 32'h1);
    cfg_write(2'd0, 32'h00);
    tick(2);
    checkOutput("t5 IRQ held", 32'(bus.IRQ), 32'h1);
    checkOutput("t5 IRQn held", 32'(bus.IRQn), 32'h010);
    ack_cycle();
    checkOutput("t5 IRQ after ack", 32'(bus.IRQ), 32'h0);
    cfg_write(2'd3, 32'h0);
    irqSrc = 8'h00;

    $display("[TB] reset during REQ");
    cfg_write(2'd0, 32'h02);
    irqSrc = 8'h02;
    tick(4);
    checkOutput("t6 IRQ before reset", 32'(bus.IRQ), 32'h1);
    nRst = 1'b0;
    #1;
    checkOutput("t6 IRQ async drop", 32'(bus.IRQ), 32'h0);
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), rd);
      checkOutput($sformatf("t6 reg%0d in reset", a), rd, 32'h0);
    end
    @(negedge clk);
    nRst = 1'b1;
    tick(6);
    checkOutput("t6 IRQ after release", 32'(bus.IRQ), 32'h0);
    irqSrc = 8'h00;

    $display("[TB] randomized run");
    do_reset();
    model_reset();
    p_src = '0; p_wr = 0; p_addr = 0; p_data = '0; p_ack = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      model_edge(p_src, p_wr, p_addr, p_data, p_ack);
      checkOutput("rnd IRQ", 32'(bus.IRQ), 32'(m_irq));
      if (m_irq) checkOutput("rnd IRQn", 32'(bus.IRQn), 32'(m_vec));
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 9) == 0) p_src[i] = ~p_src[i];
      p_wr   = ($urandom_range(0, 5) == 0);
      p_addr = int'($urandom_range(0, 3));
      p_data = $urandom;
      p_ack  = ($urandom_range(0, 3) == 0);
      irqSrc        = p_src;
      bus.cfgWrEn   = p_wr;
      bus.cfgAddr   = 2'(p_addr);
      bus.cfgDataIn = p_data;
      bus.IRQAck    = p_ack;
      #1;
      checkOutput($sformatf("rnd read addr%0d", p_addr), bus.cfgDataOut, model_read(p_addr));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Priority interrupt controller sitting between up to 16 peripheral interrupt lines and the CPU core's `IRQ`/`IRQn`/`IRQAck` handshake.
- Synchronizes and latches source requests, with per-source enable and edge/level selection.
- Picks the lowest-numbered pending enabled source and presents its 12-bit handler vector to the core.
- Holds off further requests until software signals end-of-interrupt (EOI) through a 4-word memory-mapped config window on the data bus.

## Interface
Parameters:
- `NSRC`, 8 — number of interrupt sources; legal range 1..16.
- `VEC_BASE`, 12'h010 — vector of source 0.
- `VEC_STRIDE`, 12'h004 — vector spacing between consecutive sources.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, same clock as the CPU core.
- `nRst`  in  1  asynchronous active-low reset.
- `irqSrc`  in  NSRC  raw peripheral interrupt lines, asynchronous to `clk`.
- `cfgWrEn`  in  1  config write strobe, single cycle.
- `cfgAddr`  in  2  config word select.
- `cfgDataIn`  in  32  config write data.
- `cfgDataOut`  out  32  config read data; combinational from `cfgAddr`.
- `IRQ`  out  1  interrupt request to the core.
- `IRQn`  out  12  handler vector to the core; valid while `IRQ`=1.
- `IRQAck`  in  1  acknowledge from the core.

## Operation
- **Input synchronizer.** Each `irqSrc` bit passes through a 2-flop synchronizer (`s1`, `s2`), plus a third flop `s3` used for edge detection.
- **Register map.** Bits at index ≥ NSRC read 0 and ignore writes.
  - Addr 0, ENABLE: read/write.
  - Addr 1, PENDING: read; writing a 1 clears the bit, edge-mode bits only.
  - Addr 2, EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - Addr 3, STATUS: read returns `{busy, 27'b0, idx[3:0]}`, where `busy` = state≠IDLE and `idx` is the latched source number; any write to addr 3 is the EOI.
- **Pending update (registered, every cycle):**
  - Edge bit: set on `s2 & ~s3`; cleared by a W1C write. A set and a clear in the same cycle leaves the bit set.
  - Level bit: pending <= `s2`; W1C writes have no effect.
- **Candidate selection.** `cand = PENDING & ENABLE`; the winner is the lowest set index.
- **Vector.** `IRQn = VEC_BASE + idx*VEC_STRIDE`, computed in 12 bits and wrapping modulo 4096.
- **State machine.** Three states:
  - IDLE: if `cand`≠0, latch `idx`, drive `IRQ`<=1 and `IRQn`<=vector, go to REQ.
  - REQ: hold `IRQ` and `IRQn` stable. A request is never withdrawn, even if its ENABLE bit is cleared. On `IRQAck`=1: `IRQ`<=0; if source `idx` is in edge mode, clear its PENDING bit (this clear beats a W1C but loses to a simultaneous new edge); go to SERVICE.
  - SERVICE: `IRQ`=0, and no new request is issued (no nesting). When an EOI write arrives and `IRQAck`=0, go to IDLE. If the EOI write arrives while `IRQAck`=1, record a sticky `eoiSeen` and go to IDLE on the first cycle with `IRQAck`=0.
- **Writes outside SERVICE.** An EOI write in IDLE or REQ is ignored. Writing ENABLE or EDGE in any state takes effect on the next cycle.
- **Level-mode retrigger.** A level source still asserted after EOI retriggers from IDLE.
- **Reset.** Asynchronous. Values while `nRst`=0:
  - `IRQ`=0, `IRQn`=0, state=IDLE.
  - ENABLE, PENDING, EDGE, `idx`, `eoiSeen`, and all synchronizer flops = 0.
  - `cfgDataOut` = value of the addressed register, i.e. 0.
- **Reset mid-operation.** Asserting `nRst` during REQ drops `IRQ` immediately, without waiting for a clock edge.

## Timing
- Source rises before edge k: `s1`@k, `s2`@k+1, PENDING@k+2 (both modes), `IRQ`=1 @k+3 if enabled and in IDLE.
- `IRQAck` sampled high at edge a: `IRQ`=0 after edge a, state=SERVICE.
- EOI with `IRQAck` low at edge e: IDLE after e; the next `IRQ` comes at e+1 at the earliest.
- STATUS, PENDING and other reads reflect register values as of the last edge; there is zero read latency.

## Test plan
1. ENABLE=0x3, EDGE=0x3; pulse `irqSrc[1]` high for one cycle at k. Required: `IRQ`=1 and `IRQn`=0x014 at k+3; `IRQAck`=1 → `IRQ`=0 and PENDING[1]=0; EOI with ack low → STATUS busy=0.
2. Sources 2 and 5 both rise in the same cycle, both enabled, edge mode. Required: first vector 0x018. After ack and EOI, second vector 0x024 with no extra source activity.
3. Level mode, source 0 held high across EOI. Required: `IRQ` re-asserts with 0x010 one cycle after returning to IDLE. With source 0 lowered before EOI, PENDING[0]=0 two cycles later and there is no retrigger.
4. EOI written while `IRQAck`=1, with a further pending source. Required: no new `IRQ` until the first cycle after `IRQAck` falls.
5. Edge source W1C-cleared in the same cycle as a new edge arrives. Required: PENDING stays 1. Separately, ENABLE cleared during REQ: `IRQ` remains asserted until ack.
6. `nRst` pulsed low during REQ. Required: `IRQ`=0 asynchronously, all registers read 0, and no request occurs after release until reconfiguration.
